// File: rtl/exfifo_spi_master.sv
// SPI master driven by an external command FIFO; read-back frames are written to a result FIFO.
// One command word selects a slave, sends its payload MSB first and optionally returns the received frame.
module exfifo_spi_master #(
    parameter int FIFO_W  = 32,
    parameter int N_SS    = 2,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic              clk_clk,
    input  logic              rst_reset_n,
    input  logic              en,
    input  logic [FIFO_W-1:0] exfifo_if_d,
    output logic              exfifo_if_rd,
    input  logic              exfifo_if_rdempty,
    output logic [FIFO_W-1:0] exfifo_of_d,
    output logic              exfifo_of_wr,
    input  logic              exfifo_of_wrfull,
    output logic              spi_SCLK,
    output logic              spi_MOSI,
    input  logic              spi_MISO,
    output logic [N_SS-1:0]   spi_SS_n,
    output logic              busy,
    output logic              err_ss,
    output logic [2:0]        state_dbg
);

    localparam int SHIFT_W = FIFO_W - 8;
    localparam int EDGES   = 2 * SHIFT_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W  = $clog2(EDGES + 1);
    localparam logic [7:0] N_SS_L = 8'(N_SS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SETUP = 3'd3,
        SHIFT = 3'd4,
        HOLD  = 3'd5,
        WB    = 3'd6
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DIV_W-1:0]     div_cnt;
    logic [EDGE_W-1:0]    edge_cnt;
    logic [SHIFT_W-1:0]   tx_sr;
    logic [SHIFT_W-1:0]   rx_sr;
    logic [6:0]           ss_q;
    logic                 rb_q;

    logic                 rb_in;
    logic [6:0]           ss_in;
    logic [SHIFT_W-1:0]   pay_in;
    logic                 ss_bad;
    logic [N_SS-1:0]      ss_sel;
    logic                 div_last;
    logic                 edge_last;
    logic                 in_frame;
    logic                 sclk_tick;
    logic                 update_edge;
    logic                 sample_edge;

    // Handshakes: exfifo_if_rd is a pop request issued only when rdempty is low, and the
    // popped word is valid on exfifo_if_d the following cycle. exfifo_of_wr is asserted only
    // while wrfull is low; every cycle with wr high is exactly one word accepted by the FIFO.

    assign rb_in  = exfifo_if_d[FIFO_W-1];
    assign ss_in  = exfifo_if_d[FIFO_W-2:SHIFT_W];
    assign pay_in = exfifo_if_d[SHIFT_W-1:0];
    assign ss_bad = ({1'b0, ss_in} >= N_SS_L);

    always_comb begin
        ss_sel = '0;
        for (int i = 0; i < N_SS; i++) begin
            ss_sel[i] = (ss_in == 7'(i));
        end
    end

    assign div_last    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign edge_last   = (edge_cnt == EDGE_W'(EDGES - 1));
    assign in_frame    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign sclk_tick   = (state_q == SHIFT) && div_last;
    // edge_cnt counts completed edges, so bit 0 low means the upcoming edge is odd-numbered.
    assign update_edge = sclk_tick && (edge_cnt[0] == !CPHA);
    assign sample_edge = sclk_tick && (edge_cnt[0] == CPHA);

    always_comb begin
        state_d      = state_q;
        exfifo_if_rd = 1'b0;
        exfifo_of_wr = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (en && !exfifo_if_rdempty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                exfifo_if_rd = 1'b1;
                state_d      = LATCH;
            end
            LATCH: begin
                state_d = ss_bad ? IDLE : SETUP;
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last && edge_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_d = rb_q ? WB : IDLE;
                end
            end
            WB: begin
                if (!exfifo_of_wrfull) begin
                    exfifo_of_wr = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;

    always_ff @(posedge clk_clk) begin
        if (!rst_reset_n) begin
            state_q     <= IDLE;
            div_cnt     <= '0;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            ss_q        <= '0;
            rb_q        <= 1'b0;
            spi_SCLK    <= CPOL;
            spi_MOSI    <= 1'b0;
            spi_SS_n    <= '1;
            exfifo_of_d <= '0;
            err_ss      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (in_frame) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (state_q == SHIFT) begin
                if (div_last) begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end else begin
                edge_cnt <= '0;
            end

            if (state_q == LATCH) begin
                if (ss_bad) begin
                    err_ss <= 1'b1;
                end else begin
                    ss_q     <= ss_in;
                    rb_q     <= rb_in;
                    spi_SS_n <= ~ss_sel;
                    spi_SCLK <= CPOL;
                    rx_sr    <= '0;
                    // CPHA=0 presents the MSB before the first edge; CPHA=1 shifts it out on edge 1.
                    if (CPHA) begin
                        tx_sr    <= pay_in;
                        spi_MOSI <= 1'b0;
                    end else begin
                        tx_sr    <= pay_in << 1;
                        spi_MOSI <= pay_in[SHIFT_W-1];
                    end
                end
            end

            if (sclk_tick) begin
                spi_SCLK <= ~spi_SCLK;
            end
            if (update_edge) begin
                spi_MOSI <= tx_sr[SHIFT_W-1];
                tx_sr    <= {tx_sr[SHIFT_W-2:0], 1'b0};
            end
            if (sample_edge) begin
                rx_sr <= {rx_sr[SHIFT_W-2:0], spi_MISO};
            end

            if ((state_q == HOLD) && div_last) begin
                spi_SS_n    <= '1;
                exfifo_of_d <= {1'b0, ss_q, rx_sr};
            end
        end
    end

endmodule

// File: tb/tb_exfifo_spi_master.sv
// Bench for exfifo_spi_master: SPI mode 0 and mode 3 instances, each with a FIFO model,
// a behavioural SPI slave and a write-back scoreboard.
module tb_exfifo_spi_master;

    localparam int FW = 32;
    localparam int SW = 24;
    localparam int NS = 2;
    localparam int CD = 2;

    typedef struct packed {
        logic [SW-1:0] mosi;
        logic [NS-1:0] ss_n;
        logic          busy_after;
        logic          abort;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : h
        localparam bit CP = (gi == 1);
        localparam bit CH = (gi == 1);

        logic          rst_n   = 1'b0;
        logic          en      = 1'b0;
        logic          rdempty = 1'b1;
        logic          wrfull  = 1'b0;
        logic          miso    = 1'b0;
        logic          rand_wf = 1'b0;
        logic [FW-1:0] if_d    = '0;
        logic          if_rd, of_wr, sclk, mosi, busy, err_ss;
        logic [FW-1:0] of_d;
        logic [NS-1:0] ss_n;
        logic [2:0]    st;

        logic [FW-1:0] in_q[$];
        logic [SW-1:0] miso_q[$];
        frame_t        frm_q[$];
        logic [FW-1:0] of_q[$];
        int            nedges = 0;
        time           t_drive = 0;
        time           t_fall_ss = 0;
        wire           ss_all = &ss_n;

        exfifo_spi_master #(
            .FIFO_W(FW), .N_SS(NS), .CLK_DIV(CD), .CPOL(CP), .CPHA(CH)
        ) dut (
            .clk_clk(clk), .rst_reset_n(rst_n), .en(en),
            .exfifo_if_d(if_d), .exfifo_if_rd(if_rd), .exfifo_if_rdempty(rdempty),
            .exfifo_of_d(of_d), .exfifo_of_wr(of_wr), .exfifo_of_wrfull(wrfull),
            .spi_SCLK(sclk), .spi_MOSI(mosi), .spi_MISO(miso), .spi_SS_n(ss_n),
            .busy(busy), .err_ss(err_ss), .state_dbg(st)
        );

        // Reference model: decode the command word and queue what the slave and the
        // result FIFO must observe.
        task automatic push(input logic [FW-1:0] w, input logic [SW-1:0] m, input bit abort);
            frame_t f;
            logic [6:0] ss;
            ss = w[30:24];
            in_q.push_back(w);
            rdempty = 1'b0;
            if (int'(ss) < NS) begin
                f.mosi       = w[SW-1:0];
                f.ss_n       = ~(NS'(1) << ss);
                f.busy_after = w[31] && !abort;
                f.abort      = abort;
                frm_q.push_back(f);
                miso_q.push_back(m);
                if (w[31] && !abort) of_q.push_back({1'b0, ss, m});
            end
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        endtask

        task automatic check_reset(input string name);
            chk({name, "_ss_n"}, ss_n, {NS{1'b1}});
            chk({name, "_sclk"}, sclk, CP);
            chk({name, "_mosi"}, mosi, 0);
            chk({name, "_if_rd"}, if_rd, 0);
            chk({name, "_of_wr"}, of_wr, 0);
            chk({name, "_of_d"}, of_d, 0);
            chk({name, "_busy"}, busy, 0);
            chk({name, "_err_ss"}, err_ss, 0);
        endtask

        task automatic drain(input string name);
            int n;
            n = 0;
            while (((in_q.size() + frm_q.size() + of_q.size()) != 0 || busy) && n < 6000) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            chk({name, "_drain_timeout"}, n >= 6000, 0);
        endtask

        task automatic wait_ss(input logic level, input string name);
            int n;
            n = 0;
            while (ss_all !== level && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk({name, "_wait_ss_timeout"}, n >= 3000, 0);
        endtask

        // Input FIFO model: the popped word appears on if_d the cycle after rd.
        always @(posedge clk) begin
            if (if_rd) begin
                chk("rd_when_empty", in_q.size() == 0, 0);
                if (in_q.size() > 0) if_d <= in_q.pop_front();
                rdempty <= (in_q.size() == 0);
            end
        end

        always @(posedge clk) begin
            if (rand_wf) begin
                #1;
                wrfull = ($urandom_range(0, 2) == 0);
            end
        end

        // Result FIFO monitor.
        always @(negedge clk) begin
            if (of_wr) begin
                chk("of_wr_while_wrfull", wrfull, 0);
                if (of_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL of_wr_unexpected actual=0x%0h required=no write", of_d);
                end else begin
                    chk("of_d", of_d, of_q.pop_front());
                end
            end
        end

        always @(sclk) begin
            if (rst_n === 1'b1 && ss_all === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL sclk_idle_toggle actual=%b required=%b", sclk, CP);
            end
        end

        always @(mosi) begin
            #1;
            if (rst_n && !ss_all)
                chk("mosi_change_on_drive_edge", (($time - 1) == t_drive) || (($time - 1) == t_fall_ss), 1);
        end

        // Behavioural SPI slave: leading edge leaves the idle level; CPHA selects whether
        // data is captured on the leading or the trailing edge.
        initial forever begin : slave
            frame_t        f;
            logic [SW-1:0] sr, cap;
            time           t0, t_first, t_last;
            @(negedge ss_all);
            t0 = $time;
            t_fall_ss = $time;
            t_first = 0;
            t_last = 0;
            nedges = 0;
            cap = '0;
            sr = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
            if (!CH) begin
                miso = sr[SW-1];
                sr = sr << 1;
            end
            if (frm_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spi_unexpected_frame actual=ss_n 0x%0h required=no frame", ss_n);
                f = '0;
                f.abort = 1'b1;
            end else begin
                f = frm_q.pop_front();
            end
            #1;
            if (!f.abort) chk("ss_n_select", ss_n, f.ss_n);
            if (!f.abort && !CH) chk("mosi_msb_in_setup", mosi, f.mosi[SW-1]);
            forever begin
                @(sclk or ss_all);
                if (ss_all) break;
                nedges++;
                if (nedges == 1) t_first = $time;
                t_last = $time;
                if ((sclk != CP) != CH) begin
                    cap = {cap[SW-2:0], mosi};
                end else begin
                    t_drive = $time;
                    miso = sr[SW-1];
                    sr = sr << 1;
                end
            end
            #1;
            if (!f.abort) begin
                chk("mosi_frame", cap, f.mosi);
                chk("sclk_edges", nedges, 2 * SW);
                chk("setup_plus_first_half", (t_first - t0) / 10, 2 * CD);
                chk("ss_low_cycles", ($time - 1 - t0) / 10, (2 * SW + 2) * CD);
                chk("hold_cycles", ($time - 1 - t_last) / 10, CD);
                chk("busy_after_hold", busy, f.busy_after);
            end
        end
    end

    initial begin
        logic [FW-1:0] w;
        int n;

        h[0].do_reset();
        h[1].do_reset();
        h[0].check_reset("reset0");
        h[1].check_reset("reset1");
        h[0].en = 1'b1;
        h[1].en = 1'b1;

        // Mode 0 read-back and mode 3 read-back.
        h[0].push(32'h81A5C3F0, 24'h123456, 1'b0);
        h[1].push(32'h80F00001, SW'($urandom), 1'b0);
        h[0].drain("rb_ss1");
        h[1].drain("mode3_first");
        for (int i = 0; i < 3; i++) begin
            h[1].push({1'b1, 7'($urandom_range(0, 1)), SW'($urandom)}, SW'($urandom), 1'b0);
        end
        h[1].drain("mode3_rand");

        // Write-only frame.
        h[0].push(32'h00000055, 24'hABCDEF, 1'b0);
        h[0].drain("wo_ss0");

        // Illegal slave, then a normal word; the error flag is sticky.
        h[0].push(32'h85000000, '0, 1'b0);
        n = 0;
        while (!h[0].err_ss && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("err_ss_set", h[0].err_ss, 1);
        chk("err_ss_no_select", h[0].ss_n, 2'b11);
        h[0].push(32'h80000001, SW'($urandom), 1'b0);
        h[0].drain("after_err");
        chk("err_ss_sticky", h[0].err_ss, 1);

        // Output FIFO full for 10 cycles after HOLD; a second word is queued to catch early fetches.
        h[0].wrfull = 1'b1;
        h[0].push({1'b1, 7'd1, SW'($urandom)}, SW'($urandom), 1'b0);
        h[0].push({1'b0, 7'd0, SW'($urandom)}, SW'($urandom), 1'b0);
        h[0].wait_ss(1'b0, "wf_fall");
        h[0].wait_ss(1'b1, "wf_rise");
        repeat (10) begin
            @(negedge clk);
            chk("wb_no_wr_while_full", h[0].of_wr, 0);
            chk("wb_no_fetch", h[0].if_rd, 0);
        end
        @(posedge clk);
        #1 h[0].wrfull = 1'b0;
        #1 chk("wr_on_wrfull_fall", h[0].of_wr, 1);
        h[0].drain("wrfull");

        // en falling mid-transaction lets the frame complete, then no further fetch.
        h[0].push({1'b1, 7'd0, SW'($urandom)}, SW'($urandom), 1'b0);
        h[0].wait_ss(1'b0, "en_fall");
        h[0].en = 1'b0;
        h[0].drain("en_low_finish");
        h[0].push({1'b1, 7'd1, SW'($urandom)}, SW'($urandom), 1'b0);
        repeat (30) begin
            @(negedge clk);
            chk("en_low_no_fetch", h[0].if_rd, 0);
        end
        chk("en_low_idle", h[0].busy, 0);
        h[0].en = 1'b1;
        h[0].drain("en_high_resume");

        // Randomised back-to-back commands with a randomly full output FIFO.
        h[0].rand_wf = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 2)), SW'($urandom)};
            h[0].push(w, SW'($urandom), 1'b0);
        end
        h[0].drain("random");
        h[0].rand_wf = 1'b0;
        @(negedge clk);
        h[0].wrfull = 1'b0;

        // Reset at SCLK edge 10 abandons the frame.
        h[0].push({1'b1, 7'd1, SW'($urandom)}, SW'($urandom), 1'b1);
        h[0].wait_ss(1'b0, "rst_frame");
        n = 0;
        while (h[0].nedges < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_edge10_timeout", n >= 200, 0);
        h[0].rst_n = 1'b0;
        @(negedge clk);
        h[0].check_reset("midreset");
        h[0].rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_reset_no_fetch", h[0].if_rd, 0);
        end
        chk("post_reset_busy", h[0].busy, 0);

        h[0].drain("final0");
        h[1].drain("final1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
